demux2x4_buffered: RTL and testbench
====================================

// Module: demux2x4_buffered
// PURPOSE
//   Registered 1-to-2 stream demultiplexer: the routing counterpart of the
//   Mux2x4 selector. A WIDTH-bit word on I, with select S, is written into
//   output FIFO 0 (S=0) or FIFO 1 (S=1) under a valid/ready handshake.
//   Each output has its own DEPTH-entry FIFO, so a stalled consumer blocks
//   only its own path. Sits between a single producer and two consumer
//   lanes, e.g. splitting a nibble stream between two ice40 sub-pipelines.
// PARAMETERS
//   WIDTH  4  data word width in bits (>=1)
//   DEPTH  2  entries per output FIFO; must be a power of two (2 or 4)
//   CW     derived = log2(DEPTH)+1; width of occupancy counts (not overridable)
// PORTS
//   CLK         in   1      clock; all state updates on the rising edge
//   ASYNCRESET  in   1      asynchronous reset, active-high
//   I           in   WIDTH  input data word
//   S           in   1      route select: 0 -> O0, 1 -> O1; sampled with I
//   I_valid     in   1      producer offers I/S this cycle
//   I_ready     out  1      block accepts I/S this cycle
//   O0          out  WIDTH  head word of FIFO 0
//   O0_valid    out  1      FIFO 0 non-empty
//   O0_ready    in   1      consumer 0 takes O0 this cycle
//   O1          out  WIDTH  head word of FIFO 1
//   O1_valid    out  1      FIFO 1 non-empty
//   O1_ready    in   1      consumer 1 takes O1 this cycle
//   O0_count    out  CW     FIFO 0 occupancy, 0..DEPTH
//   O1_count    out  CW     FIFO 1 occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (ASYNCRESET=1, takes effect immediately, no clock needed):
//     counts=0, read/write pointers=0, storage cleared to 0, O0/O1=0,
//     O0_valid=O1_valid=0. I_ready then follows its formula (1 after reset).
//     Reset mid-operation discards all buffered words.
//   - I_ready = S ? (O1_count!=DEPTH) : (O0_count!=DEPTH). Combinational in
//     S and registered state only. No combinational path from Ox_ready to
//     I_ready: a full FIFO refuses input even if it drains that same cycle.
//   - I_ready is independent of I_valid. S is don't-care when I_valid=0.
//   - Write: I_valid & I_ready at an edge stores I at wptr of the selected
//     FIFO; wptr increments modulo DEPTH (natural wrap).
//   - Read: Ox_valid & Ox_ready at an edge pops the head; rptr increments
//     modulo DEPTH. Ox_ready while Ox_valid=0 is ignored.
//   - Ox_valid = (Ox_count!=0). Ox = storage[rptr] (registered storage;
//     stale contents while invalid are don't-care).
//   - Latency: a word accepted at edge k appears on Ox with Ox_valid=1 after
//     edge k when that FIFO was empty. Otherwise it appears once earlier
//     words are popped.
//   - Same-FIFO write and pop on one edge: count unchanged, order kept;
//     allowed at any occupancy 1..DEPTH-1. At full, only the pop occurs.
//   - Write to one FIFO and pop of the other on one edge are independent.
//   - Ordering is FIFO per output only; no ordering between O0 and O1.
//   - Count update: count += wr - rd; never exceeds DEPTH, never below 0.
// TESTING
//   1 Reset: drive ASYNCRESET=1 between edges -> O0_valid, O1_valid,
//     O0_count and O1_count read 0 immediately; I_ready=1.
//   2 Routing: I=4'hA,S=0, then I=4'h5,S=1, each with valid and both readys
//     0 -> O0=A, O1=5, counts 1/1.
//   3 Full: DEPTH=2, O0_ready=0, send 4'h1,4'h2 to S=0 -> O0_count=2,
//     I_ready=0 for S=0 and 1 for S=1. Then 4'h3 to S=1 is accepted.
//   4 Drain/order with wrap: pop FIFO 0 -> O0 shows 1 then 2. Push 4'h4, 4'h6
//     (pointer wrap) -> popped in order 4, 6; count ends 0.
//   5 Simultaneous: FIFO 0 count=1 (head 4'h7), push 4'h8 with S=0 while
//     O0_ready=1 -> count stays 1, O0=8 next cycle.
//   6 Reset mid-stream: FIFO 0 and FIFO 1 both count=2, assert ASYNCRESET
//     -> both counts 0 and both valids 0. Next push 4'hC,S=1 -> O1=C, count 1.

Source files
------------

// File: rtl/demux2x4_buffered_if.sv
// Stream bus for the buffered 1-to-2 demultiplexer.
//   Producer side : I, S, I_valid -> block ; I_ready <- block
//   Consumer side : O0/O1, O0_valid/O1_valid, O0_count/O1_count <- block ;
//                   O0_ready/O1_ready -> block
// master = producer/consumer environment, slave = the demux itself.
interface demux2x4_buffered_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] I;
  logic             S;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O0;
  logic             O0_valid;
  logic             O0_ready;
  logic [WIDTH-1:0] O1;
  logic             O1_valid;
  logic             O1_ready;
  logic [CW-1:0]    O0_count;
  logic [CW-1:0]    O1_count;

  modport master (
    output I, S, I_valid, O0_ready, O1_ready,
    input  I_ready, O0, O0_valid, O1, O1_valid, O0_count, O1_count
  );

  modport slave (
    input  I, S, I_valid, O0_ready, O1_ready,
    output I_ready, O0, O0_valid, O1, O1_valid, O0_count, O1_count
  );
endinterface

// File: rtl/demux2x4_buffered.sv
// Registered 1-to-2 stream demultiplexer with one DEPTH-entry FIFO per output.
// A word on I is routed by S into FIFO 0 (S=0) or FIFO 1 (S=1); each output
// drains independently, so a stalled consumer only blocks its own lane.
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset, clears all state and storage
//   bus        : demux2x4_buffered_if.slave (input stream, two output streams,
//                per-output occupancy counts)

// Single output lane: DEPTH-entry circular buffer with occupancy count.
//   clk, rst : clock and asynchronous active-high reset
//   push     : write wdata this edge (caller guarantees not full)
//   ready    : consumer takes head this edge (ignored while empty)
//   head     : word at the read pointer; valid = non-empty
//   count    : occupancy 0..DEPTH; full = count==DEPTH
module demux2x4_buffered_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             pop;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid & ready;
  assign head  = mem[rptr];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module demux2x4_buffered #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input logic                 CLK,
  input logic                 ASYNCRESET,
  demux2x4_buffered_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic push0, push1;
  logic full0, full1;

  // Readiness looks only at registered occupancy: a full lane refuses input
  // even if its consumer drains it on the same edge.
  assign bus.I_ready = bus.S ? ~full1 : ~full0;
  assign push0       = bus.I_valid & bus.I_ready & ~bus.S;
  assign push1       = bus.I_valid & bus.I_ready &  bus.S;

  demux2x4_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk   (CLK),
    .rst   (ASYNCRESET),
    .push  (push0),
    .wdata (bus.I),
    .ready (bus.O0_ready),
    .head  (bus.O0),
    .valid (bus.O0_valid),
    .count (bus.O0_count),
    .full  (full0)
  );

  demux2x4_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk   (CLK),
    .rst   (ASYNCRESET),
    .push  (push1),
    .wdata (bus.I),
    .ready (bus.O1_ready),
    .head  (bus.O1),
    .valid (bus.O1_valid),
    .count (bus.O1_count),
    .full  (full1)
  );
endmodule

// File: tb/tb_demux2x4_buffered.sv
// Bench for demux2x4_buffered (WIDTH=4, DEPTH=2): per-cycle vector table,
// hand-written reset sequences, random traffic, and a queue scoreboard that
// runs on every falling edge.
module tb_demux2x4_buffered;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b0;
  logic mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  demux2x4_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux2x4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] i;
    logic       s;
    logic       v;
    logic       r0;
    logic       r1;
    logic       rdy;  // I_ready before the edge
    logic [1:0] c0;   // counts after the edge
    logic [1:0] c1;
    logic [3:0] o0;   // heads after the edge (checked when count != 0)
    logic [3:0] o1;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] i, input logic s, input logic v,
                       input logic r0, input logic r1);
    bus.I        = i;
    bus.S        = s;
    bus.I_valid  = v;
    bus.O0_ready = r0;
    bus.O1_ready = r1;
  endtask

  // Called at posedge+1; leaves the time at the following posedge+1.
  task automatic apply(input int k);
    vec_t t;
    t = tbl[k];
    drive(t.i, t.s, t.v, t.r0, t.r1);
    #2;
    check($sformatf("row%0d_i_ready", k), 32'(bus.I_ready), 32'(t.rdy));
    @(posedge CLK);
    #1;
    check($sformatf("row%0d_c0", k), 32'(bus.O0_count), 32'(t.c0));
    check($sformatf("row%0d_c1", k), 32'(bus.O1_count), 32'(t.c1));
    if (t.c0 != 2'd0) check($sformatf("row%0d_o0", k), 32'(bus.O0), 32'(t.o0));
    if (t.c1 != 2'd0) check($sformatf("row%0d_o1", k), 32'(bus.O1), 32'(t.o1));
  endtask

  task automatic assert_reset_and_check(input string tag);
    ASYNCRESET = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check({tag, "_v0"}, 32'(bus.O0_valid), 32'd0);
    check({tag, "_v1"}, 32'(bus.O1_valid), 32'd0);
    check({tag, "_c0"}, 32'(bus.O0_count), 32'd0);
    check({tag, "_c1"}, 32'(bus.O1_count), 32'd0);
    check({tag, "_o0"}, 32'(bus.O0), 32'd0);
    check({tag, "_o1"}, 32'(bus.O1), 32'd0);
    check({tag, "_i_ready"}, 32'(bus.I_ready), 32'd1);
  endtask

  // Scoreboard: state after the last edge is compared to the queues, then the
  // handshakes set up for the next edge are recorded.
  always @(negedge CLK) begin
    if (mon_en && !ASYNCRESET) begin
      check("sb_c0", 32'(bus.O0_count), 32'(q0.size()));
      check("sb_c1", 32'(bus.O1_count), 32'(q1.size()));
      check("sb_v0", 32'(bus.O0_valid), 32'(q0.size() != 0));
      check("sb_v1", 32'(bus.O1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) check("sb_o0", 32'(bus.O0), 32'(q0[0]));
      if (q1.size() != 0) check("sb_o1", 32'(bus.O1), 32'(q1[0]));
      check("sb_i_ready", 32'(bus.I_ready),
            32'(bus.S ? (q1.size() != DEPTH) : (q0.size() != DEPTH)));
      if (bus.O0_ready && q0.size() != 0) void'(q0.pop_front());
      if (bus.O1_ready && q1.size() != 0) void'(q1.pop_front());
      if (bus.I_valid && bus.I_ready) begin
        if (bus.S) q1.push_back(bus.I);
        else       q0.push_back(bus.I);
      end
    end
  end

  initial begin
    //            i     s     v     r0    r1    rdy   c0    c1    o0    o1
    tbl[0]  = '{4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'hA, 4'h0};
    tbl[1]  = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 4'hA, 4'h5};
    tbl[2]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'h1, 4'h0};
    tbl[4]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 4'h1, 4'h0};
    tbl[5]  = '{4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 4'h1, 4'h0};
    tbl[6]  = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 4'h1, 4'h3};
    tbl[7]  = '{4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 4'h2, 4'h3};
    tbl[8]  = '{4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 4'h2, 4'h3};
    tbl[9]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 4'h4, 4'h3};
    tbl[10] = '{4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 4'h4, 4'h3};
    tbl[11] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 4'h6, 4'h3};
    tbl[12] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 4'h0, 4'h3};
    tbl[13] = '{4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 4'h7, 4'h3};
    tbl[14] = '{4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 4'h8, 4'h3};
    tbl[15] = '{4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 4'h0, 4'hB};
    tbl[16] = '{4'hD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 4'hD, 4'h0};

    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted between edges, before any clock edge has occurred.
    #2;
    assert_reset_and_check("reset_initial");
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < 17; k++) apply(k);

    // Fill both lanes to DEPTH, then reset mid-cycle.
    drive(4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("fill_c0", 32'(bus.O0_count), 32'd2);
    check("fill_c1", 32'(bus.O1_count), 32'd2);
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    assert_reset_and_check("reset_mid");
    @(posedge CLK);
    #1;
    check("reset_held_c1", 32'(bus.O1_count), 32'd0);
    ASYNCRESET = 1'b0;
    drive(4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("after_reset_o1", 32'(bus.O1), 32'hC);
    check("after_reset_c1", 32'(bus.O1_count), 32'd1);
    check("after_reset_v1", 32'(bus.O1_valid), 32'd1);
    check("after_reset_c0", 32'(bus.O0_count), 32'd0);

    // Random traffic, checked by the scoreboard only.
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0));
      @(posedge CLK); #1;
    end

    drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    check("drain_c0", 32'(bus.O0_count), 32'd0);
    check("drain_c1", 32'(bus.O1_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
